sprite_frame_scheduler: RTL and testbench
=========================================

# sprite_frame_scheduler

Sequences host sprite commands onto the shared 32-bit sprite command bus that feeds every sprite display block (Goomba, Mario, tiles, …). It buffers Avalon writes in a FIFO, forces each command into the current back (hidden) buffer, and holds frame-commit markers until vertical blank. At vertical blank it issues the ping-pong flush, so sprite updates never tear on screen.

## Interface
- `DEPTH`, 64, command FIFO entries (power of two, ≥4)
- `VBLANK_LINE`, 480, first vcount value of vertical blank
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `chipselect`  in  1  Avalon slave select
- `write`  in  1  Avalon write strobe
- `read`  in  1  Avalon read strobe
- `address`  in  1  0 = command/status, 1 = commit marker
- `writedata`  in  32  host command word, same field layout as the sprite bus
- `readdata`  out  32  status word
- `vcount`  in  10  current VGA line
- `sprite_writedata`  out  32  registered command broadcast to all sprite display blocks

## Operation
- Push: `chipselect&write&address==0` pushes `{marker=0, writedata}`; `address==1` pushes `{marker=1, 32'h0}`.
- If the FIFO is full at the time of a push, the push is dropped and sticky `overflow` is set. The full test uses the pre-pop state, even if a pop occurs in the same cycle.
- Status read (`address==0`): `readdata = {overflow, 7'b0, frame_cnt[7:0], front, wait_state, 6'b0, level[7:0]}`, where `level` is FIFO occupancy. Combinational, zero wait states. A read clears `overflow` at the end of that cycle; a same-cycle overflow wins and the flag stays set.
- `back` register: the buffer that receives writes. `front = ~back`. Reset: `back=1`, matching display ping_pong reset 0.
- `vb_start`: one-cycle pulse on the rising edge of the registered `(vcount >= VBLANK_LINE)`.
- FSM:
  - RUN
    - FIFO empty: emit idle word 32'h0 (info=0 is ignored by display blocks).
    - Head is a command: emit head with bit 13 replaced by `back`, pop, stay in RUN.
    - Head is a marker: emit idle and go to WAIT. The marker is not popped.
  - WAIT: emit idle. On `vb_start`, go to FLUSH.
  - FLUSH
    - Emit flush word: info=4'hF, bit13=`back`, all other bits 0.
    - Pop the marker, toggle `back`, increment `frame_cnt` (8-bit, wraps), return to RUN.
- Commands queued behind a marker are never emitted before that marker's flush.
- Consecutive markers: each requires its own `vb_start`, one frame per marker.
- A `vb_start` arriving while in RUN or FLUSH is ignored; it is not remembered.

## Timing
- `sprite_writedata` is registered: a word decided in cycle n appears in cycle n+1 and is held for exactly one cycle.
- Empty FIFO push to bus: write in cycle 0, FIFO valid in cycle 1, on `sprite_writedata` in cycle 2.
- Throughput: one command per cycle while draining.
- Flush appears on the bus 2 cycles after the `vb_start` cycle (WAIT→FLUSH, then the output register).
- Reset values:
  - `sprite_writedata` = 0, `readdata` = 0
  - FIFO empty, state RUN
  - `back` = 1, `frame_cnt` = 0, `overflow` = 0
  - `vb_start` edge register = 0
- Reset mid-operation discards all queued commands and pending markers; no flush is emitted.

## Structure
- Package `sprite_bus_pkg` holds:
  - field bit positions: SUB_COMP 31:26, CHILD 25:21, INFO 20:17, TYPE 16:14, PP 13, MSG 12:0
  - `INFO_WRITE=4'h1`, `INFO_FLUSH=4'hF`
  - state enum `{RUN, WAIT, FLUSH}`
- Sub-module `cmd_fifo`: synchronous, 33-bit wide, `DEPTH` entries.
  - Pointer width `$clog2(DEPTH)+1`; wrap bit distinguishes full from empty.
  - Outputs `head`, `empty`, `full`, `level`.
  - Simultaneous push and pop when non-full keeps `level` unchanged.

## Test plan
- Reset, then push 0x1402_4000 (sub 5, child 0, info 1, type 1, pp 0) → bus shows 0x1402_6000 (pp forced to 1) two cycles later, for one cycle; then 0.
- Push cmd A, marker, cmd B; raise vcount to 480 → A emitted immediately; B is held. Flush 0x001E_2000 appears 2 cycles after `vb_start`. B is then emitted with pp=0, and `front` reads 1.
- Push DEPTH+1 commands with no drain (marker at head, no vblank) → `level`=DEPTH, `overflow`=1. A status read returns overflow=1; the next read returns 0.
- Two back-to-back markers → exactly one flush per vblank edge; `frame_cnt` goes 0→1→2 across two frames; pp alternates 1,0.
- Assert reset while in WAIT with 5 entries queued → bus 0, level 0, `back`=1. The next vblank produces no flush.
- vcount held ≥480 for many lines → a single `vb_start`, hence only one flush.

Source files
------------

// File: rtl/sprite_bus_pkg.sv
// Field layout and shared constants for the 32-bit sprite command bus.
package sprite_bus_pkg;

    localparam int SUB_COMP_MSB = 31;
    localparam int SUB_COMP_LSB = 26;
    localparam int CHILD_MSB    = 25;
    localparam int CHILD_LSB    = 21;
    localparam int INFO_MSB     = 20;
    localparam int INFO_LSB     = 17;
    localparam int TYPE_MSB     = 16;
    localparam int TYPE_LSB     = 14;
    localparam int PP_BIT       = 13;
    localparam int MSG_MSB      = 12;
    localparam int MSG_LSB      = 0;

    localparam logic [3:0] INFO_WRITE = 4'h1;
    localparam logic [3:0] INFO_FLUSH = 4'hF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    // Ping-pong flush command: only INFO and PP are non-zero.
    function automatic logic [31:0] flush_word(input logic pp);
        logic [31:0] w;
        w = 32'h0;
        w[INFO_MSB:INFO_LSB] = INFO_FLUSH;
        w[PP_BIT] = pp;
        return w;
    endfunction

endpackage

// File: rtl/sprite_frame_scheduler_cmd_fifo.sv
// Synchronous command FIFO; the extra pointer bit separates full from empty.
module cmd_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 33,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Drains host sprite commands onto the sprite bus, holding frame commits until vblank.
module sprite_frame_scheduler
    import sprite_bus_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int VBLANK_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic        address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  vcount,
    output logic [31:0] sprite_writedata
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [9:0] VB_LINE = 10'(VBLANK_LINE);

    sched_state_t state, next_state;
    logic         back;
    logic [7:0]   frame_cnt;
    logic         overflow;
    logic         vb_level_q;
    logic         vb_prev_q;
    logic         vb_start;

    logic         fifo_push;
    logic         fifo_pop;
    logic [32:0]  fifo_din;
    logic [32:0]  fifo_head;
    logic         fifo_empty;
    logic         fifo_full;
    logic [LW-1:0] fifo_level;
    logic [7:0]   level8;

    logic [31:0]  next_word;
    logic         do_flush;
    logic         ovf_set;
    logic         status_rd;

    assign fifo_push = chipselect && write;
    assign fifo_din  = address ? {1'b1, 32'h0} : {1'b0, writedata};
    // Full is judged before any same-cycle pop, so a push into a full FIFO is always lost.
    assign ovf_set   = fifo_push && fifo_full;
    assign status_rd = chipselect && read && !address;
    assign vb_start  = vb_level_q && !vb_prev_q;
    assign level8    = 8'(fifo_level);

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        next_state = state;
        next_word  = 32'h0;
        fifo_pop   = 1'b0;
        do_flush   = 1'b0;
        case (state)
            RUN: begin
                if (!fifo_empty) begin
                    if (fifo_head[32]) begin
                        next_state = WAIT;
                    end else begin
                        next_word         = fifo_head[31:0];
                        next_word[PP_BIT] = back;
                        fifo_pop          = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (vb_start) next_state = FLUSH;
            end
            FLUSH: begin
                next_word  = flush_word(back);
                fifo_pop   = 1'b1;
                do_flush   = 1'b1;
                next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= RUN;
            sprite_writedata <= 32'h0;
            back             <= 1'b1;
            frame_cnt        <= 8'h0;
            overflow         <= 1'b0;
            vb_level_q       <= 1'b0;
            vb_prev_q        <= 1'b0;
        end else begin
            state            <= next_state;
            sprite_writedata <= next_word;
            vb_level_q       <= (vcount >= VB_LINE);
            vb_prev_q        <= vb_level_q;
            if (do_flush) begin
                back      <= ~back;
                frame_cnt <= frame_cnt + 8'h1;
            end
            if (ovf_set)        overflow <= 1'b1;
            else if (status_rd) overflow <= 1'b0;
        end
    end

    assign readdata = status_rd
        ? {overflow, 7'b0, frame_cnt, ~back, (state == WAIT), 6'b0, level8}
        : 32'h0;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler: drain timing, frame commits, overflow, reset.
module tb_sprite_frame_scheduler;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic        address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  vcount;
    logic [31:0] sprite_writedata;

    int n_cmp = 0;
    int n_err = 0;

    sprite_frame_scheduler #(.DEPTH(DEPTH), .VBLANK_LINE(480)) dut (
        .clk              (clk),
        .reset            (reset),
        .chipselect       (chipselect),
        .write            (write),
        .read             (read),
        .address          (address),
        .writedata        (writedata),
        .readdata         (readdata),
        .vcount           (vcount),
        .sprite_writedata (sprite_writedata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic adr, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = adr; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0; address = 1'b0; writedata = 32'h0;
    endtask

    task automatic read_status(output logic [31:0] v);
        chipselect = 1'b1; read = 1'b1; address = 1'b0;
        #1;
        v = readdata;
        tick();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 1'b0; writedata = 32'h0; vcount = 10'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 1'b0; writedata = 32'h0; vcount = 10'd0;
        #1;
        n_cmp++; if (sprite_writedata !== 32'h0) begin n_err++; $display("FAIL reset_bus: got %h want %h", sprite_writedata, 32'h0); end
        n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0); end
        chipselect = 1'b1; read = 1'b1;
        #1;
        n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want %h", readdata, 32'h0); end
        chipselect = 1'b0; read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_cmd();
        do_reset();
        push(1'b0, 32'h1402_4000);
        n_cmp++; if (sprite_writedata !== 32'h0) begin n_err++; $display("FAIL single_cycle1: got %h want %h", sprite_writedata, 32'h0); end
        tick();
        n_cmp++; if (sprite_writedata !== 32'h1402_6000) begin n_err++; $display("FAIL single_cycle2: got %h want %h", sprite_writedata, 32'h1402_6000); end
        tick();
        n_cmp++; if (sprite_writedata !== 32'h0) begin n_err++; $display("FAIL single_cycle3: got %h want %h", sprite_writedata, 32'h0); end
    endtask

    task automatic test_marker_hold();
        logic [31:0] st;
        int          held;
        do_reset();
        push(1'b0, 32'h1402_4001);
        push(1'b1, 32'h0);
        n_cmp++; if (sprite_writedata !== 32'h1402_6001) begin n_err++; $display("FAIL hold_cmd_a: got %h want %h", sprite_writedata, 32'h1402_6001); end
        push(1'b0, 32'h1402_6002);
        held = 0;
        for (int i = 0; i < 3; i++) begin
            if (sprite_writedata != 32'h0) held++;
            tick();
        end
        n_cmp++; if (held !== 0) begin n_err++; $display("FAIL hold_b_blocked: got %0d nonzero words want 0", held); end
        read_status(st);
        n_cmp++; if (st !== 32'h0000_4002) begin n_err++; $display("FAIL hold_status_wait: got %h want %h", st, 32'h0000_4002); end
        vcount = 10'd480;
        tick();
        tick();
        n_cmp++; if (sprite_writedata !== 32'h0) begin n_err++; $display("FAIL hold_pre_flush: got %h want %h", sprite_writedata, 32'h0); end
        tick();
        n_cmp++; if (sprite_writedata !== 32'h001E_2000) begin n_err++; $display("FAIL hold_flush: got %h want %h", sprite_writedata, 32'h001E_2000); end
        tick();
        n_cmp++; if (sprite_writedata !== 32'h1402_4002) begin n_err++; $display("FAIL hold_cmd_b: got %h want %h", sprite_writedata, 32'h1402_4002); end
        tick();
        n_cmp++; if (sprite_writedata !== 32'h0) begin n_err++; $display("FAIL hold_after_b: got %h want %h", sprite_writedata, 32'h0); end
        read_status(st);
        n_cmp++; if (st !== 32'h0001_8000) begin n_err++; $display("FAIL hold_status_front: got %h want %h", st, 32'h0001_8000); end
        vcount = 10'd0;
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        do_reset();
        push(1'b1, 32'h0);
        for (int i = 0; i < DEPTH; i++) push(1'b0, 32'h1402_4000 | 32'(i));
        n_cmp++; if (sprite_writedata !== 32'h0) begin n_err++; $display("FAIL ovf_bus_idle: got %h want %h", sprite_writedata, 32'h0); end
        read_status(st);
        n_cmp++; if (st !== 32'h8000_4040) begin n_err++; $display("FAIL ovf_first_read: got %h want %h", st, 32'h8000_4040); end
        read_status(st);
        n_cmp++; if (st !== 32'h0000_4040) begin n_err++; $display("FAIL ovf_cleared: got %h want %h", st, 32'h0000_4040); end
        chipselect = 1'b1; write = 1'b1; read = 1'b1; address = 1'b0; writedata = 32'h1402_4077;
        #1;
        n_cmp++; if (readdata !== 32'h0000_4040) begin n_err++; $display("FAIL ovf_same_cycle_read: got %h want %h", readdata, 32'h0000_4040); end
        tick();
        chipselect = 1'b0; write = 1'b0; read = 1'b0; writedata = 32'h0;
        read_status(st);
        n_cmp++; if (st !== 32'h8000_4040) begin n_err++; $display("FAIL ovf_set_wins: got %h want %h", st, 32'h8000_4040); end
        read_status(st);
        n_cmp++; if (st !== 32'h0000_4040) begin n_err++; $display("FAIL ovf_cleared_again: got %h want %h", st, 32'h0000_4040); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] st;
        int          flushes;
        do_reset();
        push(1'b1, 32'h0);
        push(1'b1, 32'h0);
        tick();
        read_status(st);
        n_cmp++; if (st !== 32'h0000_4002) begin n_err++; $display("FAIL b2b_status0: got %h want %h", st, 32'h0000_4002); end
        vcount = 10'd480;
        tick(); tick(); tick();
        n_cmp++; if (sprite_writedata !== 32'h001E_2000) begin n_err++; $display("FAIL b2b_flush1: got %h want %h", sprite_writedata, 32'h001E_2000); end
        flushes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sprite_writedata[20:17] == 4'hF) flushes++;
        end
        n_cmp++; if (flushes !== 0) begin n_err++; $display("FAIL b2b_no_extra_flush: got %0d want 0", flushes); end
        read_status(st);
        n_cmp++; if (st !== 32'h0001_C001) begin n_err++; $display("FAIL b2b_status1: got %h want %h", st, 32'h0001_C001); end
        vcount = 10'd0;
        tick(); tick();
        vcount = 10'd480;
        tick(); tick(); tick();
        n_cmp++; if (sprite_writedata !== 32'h001E_0000) begin n_err++; $display("FAIL b2b_flush2: got %h want %h", sprite_writedata, 32'h001E_0000); end
        tick();
        read_status(st);
        n_cmp++; if (st !== 32'h0002_0000) begin n_err++; $display("FAIL b2b_status2: got %h want %h", st, 32'h0002_0000); end
        vcount = 10'd0;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] st;
        int          nz;
        do_reset();
        push(1'b1, 32'h0);
        for (int i = 0; i < 4; i++) push(1'b0, 32'h1402_4010 + 32'(i));
        tick();
        read_status(st);
        n_cmp++; if (st !== 32'h0000_4005) begin n_err++; $display("FAIL rst_wait_status: got %h want %h", st, 32'h0000_4005); end
        reset = 1'b1;
        #1;
        n_cmp++; if (sprite_writedata !== 32'h0) begin n_err++; $display("FAIL rst_wait_bus: got %h want %h", sprite_writedata, 32'h0); end
        read_status(st);
        n_cmp++; if (st !== 32'h0) begin n_err++; $display("FAIL rst_wait_in_reset: got %h want %h", st, 32'h0); end
        reset = 1'b0;
        tick();
        vcount = 10'd480;
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sprite_writedata != 32'h0) nz++;
        end
        n_cmp++; if (nz !== 0) begin n_err++; $display("FAIL rst_wait_no_flush: got %0d nonzero words want 0", nz); end
        read_status(st);
        n_cmp++; if (st !== 32'h0) begin n_err++; $display("FAIL rst_wait_after: got %h want %h", st, 32'h0); end
        vcount = 10'd0;
    endtask

    task automatic test_long_vblank();
        logic [31:0] st;
        int          flushes;
        do_reset();
        push(1'b1, 32'h0);
        push(1'b1, 32'h0);
        tick();
        flushes = 0;
        for (int i = 0; i < 50; i++) begin
            vcount = 10'(480 + i);
            tick();
            if (sprite_writedata[20:17] == 4'hF) flushes++;
        end
        n_cmp++; if (flushes !== 1) begin n_err++; $display("FAIL long_vb_flushes: got %0d want 1", flushes); end
        read_status(st);
        n_cmp++; if (st !== 32'h0001_C001) begin n_err++; $display("FAIL long_vb_status: got %h want %h", st, 32'h0001_C001); end
        vcount = 10'd0;
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_marker_hold();
        test_overflow();
        test_back_to_back();
        test_reset_in_wait();
        test_long_vblank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
